mem_port_arbiter: RTL and testbench

//  Shares one external memory port between instruction fetch (IF, read-only) and the MEM-stage

---
 rtl/mips_defines.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 29 ++
 rtl/mem_arb_pick.sv | 17 +
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_defines.sv
// Shared definitions for the memory-port arbiter: state encoding,
// default bus widths and the byte-enable pattern used for fetches.
package mips_defines;

    localparam int ARB_AW         = 32;
    localparam int ARB_DW         = 32;
    localparam int ARB_BW         = ARB_DW / 8;
    localparam int ARB_MAX_LS_RUN = 4;

    // Instruction fetches always read the full word.
    localparam logic [ARB_BW-1:0] ARB_IF_BE = '1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_LS = 2'd2
    } arb_state_t;

    // Byte-enable width for a given data width.
    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side request/acknowledge bus between the arbiter (master)
// and the ROM/RAM port (slave).
interface mem_port_arbiter_if
    import mips_defines::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
);
    localparam int BW = DW / 8;

    logic          bus_req;
    logic          bus_we;
    logic [BW-1:0] bus_be;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between instruction fetch and load/store.
// Requests arrive already qualified by the arbitration point.
module mem_arb_pick (
    input  logic if_req,
    input  logic ls_req,
    input  logic run_sat,
    output logic gnt_if,
    output logic gnt_ls
);

    // LS wins unless it has used up its run while a fetch is waiting
    always_comb begin
        gnt_ls = ls_req && !(if_req && run_sat);
        gnt_if = if_req && !gnt_ls;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the
// load/store unit. A granted request is latched onto the bus, held until
// the slave acknowledges, and its data is returned to the owner. The
// arbiter re-arbitrates in the acknowledge cycle so back-to-back
// transactions run without an idle bus cycle.
module mem_port_arbiter
    import mips_defines::*;
#(
    parameter int AW         = ARB_AW,
    parameter int DW         = ARB_DW,
    parameter int MAX_LS_RUN = ARB_MAX_LS_RUN
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  if_req,
    input  logic [AW-1:0]         if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DW-1:0]         if_rdata,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [DW/8-1:0]       ls_be,
    input  logic [AW-1:0]         ls_addr,
    input  logic [DW-1:0]         ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DW-1:0]         ls_rdata,

    mem_port_arbiter_if.master    bus,

    output logic                  stall_req
);

    localparam int BW   = DW / 8;
    localparam int RUNW = $clog2(MAX_LS_RUN + 1);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [RUNW-1:0] ls_run_q;

    logic          arb_point;
    logic          run_sat;
    logic          gnt_if;
    logic          gnt_ls;

    logic          bus_req_q;
    logic          bus_we_q;
    logic [BW-1:0] bus_be_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_wdata_q;

    logic          if_rvalid_q;
    logic [DW-1:0] if_rdata_q;
    logic          ls_rvalid_q;
    logic [DW-1:0] ls_rdata_q;

    // A new winner may be chosen when idle or when the current transfer completes.
    // Grants are also held off while reset is asserted so nothing upstream advances.
    assign arb_point = (state_q == ARB_IDLE) || bus.bus_ack;
    assign run_sat   = (ls_run_q == RUNW'(MAX_LS_RUN));

    mem_arb_pick u_pick (
        .if_req  (if_req && arb_point && reset),
        .ls_req  (ls_req && arb_point && reset),
        .run_sat (run_sat),
        .gnt_if  (gnt_if),
        .gnt_ls  (gnt_ls)
    );

    assign if_gnt = gnt_if;
    assign ls_gnt = gnt_ls;

    // The pipeline stalls while a transfer is outstanding or a request is refused.
    assign stall_req = (state_q != ARB_IDLE) || ((if_req || ls_req) && !(gnt_if || gnt_ls));

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only changes at an arbitration point, to the winner or back to idle
    always_comb begin
        state_d = state_q;
        if (arb_point) begin
            if (gnt_ls) begin
                state_d = ARB_BUSY_LS;
            end else if (gnt_if) begin
                state_d = ARB_BUSY_IF;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    // Count consecutive LS grants taken while a fetch was waiting, cleared when IF wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ls_run_q <= '0;
        end else if (gnt_if) begin
            ls_run_q <= '0;
        end else if (gnt_ls && if_req && !run_sat) begin
            ls_run_q <= ls_run_q + RUNW'(1);
        end
    end

    // Bus registers: load the winner on grant, hold while busy, drop the request when nothing follows
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else if (gnt_ls) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= ls_we;
            bus_be_q    <= ls_be;
            bus_addr_q  <= ls_addr;
            bus_wdata_q <= ls_wdata;
        end else if (gnt_if) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_be_q    <= {BW{1'b1}};
            bus_addr_q  <= if_addr;
            bus_wdata_q <= '0;
        end else if (arb_point) begin
            bus_req_q   <= 1'b0;
        end
    end

    // Completion: capture read data for the owner and pulse its rvalid for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if (bus.bus_ack && (state_q == ARB_BUSY_IF)) begin
                if_rvalid_q <= 1'b1;
                if_rdata_q  <= bus.bus_rdata;
            end
            if (bus.bus_ack && (state_q == ARB_BUSY_LS)) begin
                ls_rvalid_q <= 1'b1;
                ls_rdata_q  <= bus_we_q ? '0 : bus.bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural model of the arbitration rules
// and a scoreboard of expected completions.
module tb_mem_port_arbiter;
    import mips_defines::*;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int BW      = DW / 8;
    localparam int MAX_RUN = 4;

    typedef struct {
        bit            is_ls;
        logic [DW-1:0] data;
    } resp_t;

    typedef struct packed {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [BW-1:0] ls_be = '0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_gnt, ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          stall_req;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LS_RUN(MAX_RUN)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .bus       (bus.master),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    resp_t sb[$];
    string gnt_log[$];

    // requester state
    bit            if_pend = 0, ls_pend = 0;
    logic [AW-1:0] if_a = '0, ls_a = '0;
    logic          ls_w = 1'b0;
    logic [BW-1:0] ls_b = '0;
    logic [DW-1:0] ls_d = '0;
    bit            cont_if = 0, cont_ls = 0, rand_mode = 0;

    // memory slave state
    int            fixed_delay = 0;
    bit            rand_delay = 0, stray_ack = 0, slv_active = 0;
    int            slv_cnt = 0;

    // reference model state
    bit            m_busy = 0;
    int            m_run = 0;
    bus_t          m_cur;
    bit            last_if_gnt = 0, last_ls_gnt = 0;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the arbitration rules for this cycle, then advance the model.
    task automatic model_step();
        bit arb, exp_ls, exp_if, exp_stall;
        arb       = !m_busy || bus.bus_ack;
        exp_ls    = arb && ls_req && !(if_req && m_run == MAX_RUN);
        exp_if    = arb && if_req && !exp_ls;
        exp_stall = m_busy || ((if_req || ls_req) && !(exp_if || exp_ls));
        checkOutput("if_gnt", if_gnt, exp_if);
        checkOutput("ls_gnt", ls_gnt, exp_ls);
        checkOutput("stall_req", stall_req, exp_stall);
        checkOutput("bus_req", bus.bus_req, m_busy);
        if (m_busy) begin
            checkOutput("bus_we", bus.bus_we, m_cur.we);
            checkOutput("bus_be", bus.bus_be, m_cur.be);
            checkOutput("bus_addr", bus.bus_addr, m_cur.addr);
            checkOutput("bus_wdata", bus.bus_wdata, m_cur.wdata);
        end
        last_if_gnt = if_gnt;
        last_ls_gnt = ls_gnt;
        if (if_gnt) gnt_log.push_back("I");
        if (ls_gnt) gnt_log.push_back("L");
        if (exp_ls) begin
            if (if_req) m_run = (m_run < MAX_RUN) ? m_run + 1 : MAX_RUN;
            m_busy = 1;
            m_cur  = '{ls_we, ls_be, ls_addr, ls_wdata};
            sb.push_back('{1'b1, ls_we ? '0 : mem_data(ls_addr)});
            ls_pend = 0;
        end else if (exp_if) begin
            m_run  = 0;
            m_busy = 1;
            m_cur  = '{1'b0, {BW{1'b1}}, if_addr, {DW{1'b0}}};
            sb.push_back('{1'b0, mem_data(if_addr)});
            if_pend = 0;
        end else if (arb) begin
            m_busy = 0;
        end
    endtask

    // One clock: drive requester and slave after the edge, check mid-cycle.
    task automatic applyStimulus();
        logic ack;
        @(posedge clk);
        #1;
        if (rand_mode) begin
            if (!if_pend && $urandom_range(0, 3) == 0) begin
                if_pend = 1;
                if_a    = $urandom & 32'hFFFF_FFFC;
            end else if (if_pend && $urandom_range(0, 15) == 0) begin
                if_pend = 0;
            end
            if (!ls_pend && $urandom_range(0, 3) == 0) begin
                ls_pend = 1;
                ls_w    = $urandom_range(0, 1);
                ls_b    = BW'($urandom);
                ls_a    = $urandom & 32'hFFFF_FFFC;
                ls_d    = $urandom;
            end else if (ls_pend && $urandom_range(0, 15) == 0) begin
                ls_pend = 0;
            end
        end
        if (cont_if && !if_pend) begin
            if_pend = 1;
            if_a    = if_a + 4;
        end
        if (cont_ls && !ls_pend) begin
            ls_pend = 1;
            ls_w    = 1'b0;
            ls_a    = ls_a + 4;
        end
        if_req   = if_pend;
        if_addr  = if_a;
        ls_req   = ls_pend;
        ls_we    = ls_w;
        ls_be    = ls_b;
        ls_addr  = ls_a;
        ls_wdata = ls_d;

        ack = 1'b0;
        if (bus.bus_req) begin
            if (!slv_active) begin
                slv_active = 1;
                slv_cnt    = rand_delay ? int'($urandom_range(0, 5)) : fixed_delay;
            end
            if (slv_cnt == 0) begin
                ack        = 1'b1;
                slv_active = 0;
            end else begin
                slv_cnt--;
            end
        end else begin
            slv_active = 0;
            if (stray_ack) ack = 1'b1;
        end
        bus.bus_ack   = ack;
        bus.bus_rdata = ack ? mem_data(bus.bus_addr) : DW'($urandom);

        @(negedge clk);
        model_step();
    endtask

    task automatic wait_grant(input bit want_ls, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            applyStimulus();
            seen = want_ls ? last_ls_gnt : last_if_gnt;
        end
        checkOutput(want_ls ? "ls_grant_timeout" : "if_grant_timeout", seen, 1'b1);
    endtask

    function automatic string join_log();
        string s = "";
        foreach (gnt_log[i]) s = {s, gnt_log[i]};
        return s;
    endfunction

    // Monitor: every completion must match the oldest outstanding grant.
    logic [DW-1:0] hold_if = '0, hold_ls = '0;
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_if = '0;
                hold_ls = '0;
            end else begin
                checkOutput("rvalid_exclusive", if_rvalid && ls_rvalid, 1'b0);
                if (if_rvalid || ls_rvalid) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_rvalid", 1'b1, 1'b0);
                    end else begin
                        r = sb.pop_front();
                        checkOutput("rvalid_owner", ls_rvalid, r.is_ls);
                        if (if_rvalid) hold_if = r.data;
                        if (ls_rvalid) hold_ls = r.data;
                    end
                end
                checkOutput("if_rdata", if_rdata, hold_if);
                checkOutput("ls_rdata", ls_rdata, hold_ls);
            end
        end
    end

    initial begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = '0;

        // reset state
        #3;
        checkOutput("rst_if_gnt", if_gnt, 1'b0);
        checkOutput("rst_ls_gnt", ls_gnt, 1'b0);
        checkOutput("rst_if_rvalid", if_rvalid, 1'b0);
        checkOutput("rst_ls_rvalid", ls_rvalid, 1'b0);
        checkOutput("rst_if_rdata", if_rdata, '0);
        checkOutput("rst_ls_rdata", ls_rdata, '0);
        checkOutput("rst_bus_req", bus.bus_req, 1'b0);
        checkOutput("rst_bus_we", bus.bus_we, 1'b0);
        checkOutput("rst_bus_be", bus.bus_be, '0);
        checkOutput("rst_bus_addr", bus.bus_addr, '0);
        checkOutput("rst_bus_wdata", bus.bus_wdata, '0);
        checkOutput("rst_stall", stall_req, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        applyStimulus();

        // single fetch, ack on the third bus cycle
        $display("[TB] fetch with 3-cycle ack");
        fixed_delay = 2;
        if_pend = 1;
        if_a    = 32'h100;
        wait_grant(0, 20);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus();
            checkOutput("t2_bus_req", bus.bus_req, 1'b1);
            checkOutput("t2_bus_addr", bus.bus_addr, 32'h100);
            checkOutput("t2_stall", stall_req, 1'b1);
        end
        applyStimulus();
        checkOutput("t2_if_rvalid", if_rvalid, 1'b1);
        checkOutput("t2_if_rdata", if_rdata, mem_data(32'h100));
        checkOutput("t2_stall_done", stall_req, 1'b0);

        // simultaneous requests: LS first, IF taken on the LS ack cycle
        $display("[TB] simultaneous IF and LS");
        fixed_delay = 1;
        gnt_log.delete();
        if_pend = 1; if_a = 32'h300;
        ls_pend = 1; ls_a = 32'h40; ls_w = 1'b0; ls_b = '1; ls_d = '0;
        for (int i = 0; i < 30 && gnt_log.size() < 2; i++) applyStimulus();
        checkOutput("t3_bus_req_at_switch", bus.bus_req, 1'b1);
        applyStimulus();
        checkOutput("t3_bus_req_after", bus.bus_req, 1'b1);
        checkOutput("t3_bus_addr_after", bus.bus_addr, 32'h300);
        checks++;
        if (join_log() != "LI") begin
            errors++;
            $display("[TB] FAIL t3_order: got %s, expected LI", join_log());
        end
        repeat (6) applyStimulus();

        // stray ack while idle, then a partial write
        $display("[TB] stray ack and LS write");
        stray_ack = 1;
        applyStimulus();
        stray_ack = 0;
        applyStimulus();
        checkOutput("t5_no_rvalid", if_rvalid || ls_rvalid, 1'b0);
        ls_pend = 1; ls_w = 1'b1; ls_b = 4'b0011; ls_a = 32'h80; ls_d = 32'h1234;
        wait_grant(1, 20);
        applyStimulus();
        checkOutput("t5_bus_we", bus.bus_we, 1'b1);
        checkOutput("t5_bus_be", bus.bus_be, 4'b0011);
        applyStimulus();
        applyStimulus();
        checkOutput("t5_ls_rvalid", ls_rvalid, 1'b1);
        checkOutput("t5_ls_rdata", ls_rdata, '0);
        repeat (3) applyStimulus();

        // continuous contention: LS run limit forces IF every fifth grant
        $display("[TB] LS run limit");
        fixed_delay = 0;
        gnt_log.delete();
        cont_if = 1; cont_ls = 1;
        for (int i = 0; i < 100 && gnt_log.size() < 10; i++) applyStimulus();
        cont_if = 0; cont_ls = 0;
        checks++;
        if (join_log().substr(0, 9) != "LLLLILLLLI") begin
            errors++;
            $display("[TB] FAIL t4_order: got %s, expected LLLLILLLLI", join_log());
        end
        if_pend = 0; ls_pend = 0;
        repeat (6) applyStimulus();

        // reset in the middle of an LS transfer
        $display("[TB] reset during LS transfer");
        fixed_delay = 5;
        ls_pend = 1; ls_w = 1'b0; ls_b = '1; ls_a = 32'h200;
        wait_grant(1, 20);
        applyStimulus();
        applyStimulus();
        ls_pend = 1; ls_a = 32'h204;
        applyStimulus();
        #2 reset = 1'b0;
        #1;
        checkOutput("t1_bus_req", bus.bus_req, 1'b0);
        checkOutput("t1_if_gnt", if_gnt, 1'b0);
        checkOutput("t1_ls_gnt", ls_gnt, 1'b0);
        checkOutput("t1_if_rvalid", if_rvalid, 1'b0);
        checkOutput("t1_ls_rvalid", ls_rvalid, 1'b0);
        ls_req = 1'b0; if_req = 1'b0; bus.bus_ack = 1'b0;
        ls_pend = 0; if_pend = 0; slv_active = 0;
        m_busy = 0; m_run = 0; sb.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (3) applyStimulus();

        // random traffic
        $display("[TB] random traffic");
        rand_mode = 1; rand_delay = 1;
        repeat (10000) applyStimulus();
        rand_mode = 0; if_pend = 0; ls_pend = 0;
        repeat (20) applyStimulus();
        checkOutput("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
